// File: rtl/shift_deser_pkg.sv
// Shared constants for the shift_deser serial word receiver.
package shift_deser_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam logic DIR_LSB_FIRST = 1'b0;
  localparam logic DIR_MSB_FIRST = 1'b1;

endpackage

// File: rtl/shift_deser_core.sv
// Bidirectional serial-in shift register with a bit counter.
// word is the next shift value, so the top can capture the completed word on the final edge.
module shift_deser_core
  import shift_deser_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             en,
  input  logic             dir,
  input  logic             sin,
  output logic [WIDTH-1:0] word,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             shift;

  assign shift = en && !clr;

  always_comb begin
    sr_d = (dir == DIR_MSB_FIRST) ? {sr_q[WIDTH-2:0], sin} : {sin, sr_q[WIDTH-1:1]};
    done = shift && (cnt_q == CW'(WIDTH - 1));
    word = sr_d;

    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = done ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (shift) begin
        sr_q <= sr_d;
      end
    end
  end

endmodule

// File: rtl/shift_deser.sv
// Serial-in, parallel-out word receiver with a double-buffered valid/ready output
// and a sticky overrun flag for words dropped while the holding register is full.
module shift_deser
  import shift_deser_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             DIR,
  input  logic             SIN,
  input  logic             SIN_VALID,
  output logic [WIDTH-1:0] DOUT,
  output logic             DOUT_VALID,
  input  logic             DOUT_READY,
  output logic             BUSY,
  output logic             OVERRUN,
  input  logic             CLR_OVR
);

  state_e           state_q, state_d;
  logic             dir_q;
  logic [WIDTH-1:0] dout_q;
  logic             dout_valid_q;
  logic             busy_q;
  logic             overrun_q;

  logic [WIDTH-1:0] word;
  logic             done;
  logic             shift_en;
  logic             accept;
  logic             drop;

  // START wins over SIN_VALID, so a START cycle never shifts.
  assign shift_en = (state_q == ST_SHIFT) && SIN_VALID && !START;

  shift_deser_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .CLK (CLK),
    .RST (RST),
    .clr (START),
    .en  (shift_en),
    .dir (dir_q),
    .sin (SIN),
    .word(word),
    .done(done)
  );

  // A completed word is taken if the holding register is empty or being drained this cycle.
  assign accept = done && (!dout_valid_q || DOUT_READY);
  assign drop   = done && dout_valid_q && !DOUT_READY;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (START) state_d = ST_SHIFT;
      ST_SHIFT: if (!START && done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      dir_q        <= DIR_LSB_FIRST;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == ST_SHIFT);
      if (START) begin
        dir_q <= DIR;
      end

      if (accept) begin
        dout_q       <= word;
        dout_valid_q <= 1'b1;
      end else if (dout_valid_q && DOUT_READY) begin
        dout_valid_q <= 1'b0;
      end

      if (drop) begin
        overrun_q <= 1'b1;
      end else if (CLR_OVR) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign DOUT       = dout_q;
  assign DOUT_VALID = dout_valid_q;
  assign BUSY       = busy_q;
  assign OVERRUN    = overrun_q;

endmodule
